// File: rtl/pipe_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, FSM state encoding
// and the helper that picks out the operations handled by the iterative unit.
package pipe_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_REMU  = 4'd12;
  localparam logic [3:0] OP_PASSB = 4'd13;
  localparam logic [3:0] OP_PASSA = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply / unsigned divide datapath: one shift-add or restoring-divide
// step per i_step; the step count is owned by the caller.
module mdu_iter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_step,
  input  logic [3:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result
);

  logic [3:0]   r_op;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_b;
  logic [W-1:0] r_q;
  logic [W-1:0] r_rem;

  logic [W:0]   w_shifted;
  logic [W-1:0] w_diff;
  logic         w_fits;

  // A zero divisor always "fits", which naturally yields all-ones quotient and remainder = dividend.
  always_comb begin
    w_shifted = {r_rem, r_q[W-1]};
    w_fits    = (w_shifted >= {1'b0, r_b});
    w_diff    = w_shifted[W-1:0] - r_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= OP_ADD;
      r_acc <= '0;
      r_b   <= '0;
      r_q   <= '0;
      r_rem <= '0;
    end else if (i_start) begin
      r_op  <= i_op;
      r_acc <= '0;
      r_rem <= '0;
      r_b   <= (i_op == OP_MUL) ? i_a : i_b;
      r_q   <= (i_op == OP_MUL) ? i_b : i_a;
    end else if (i_step) begin
      if (r_op == OP_MUL) begin
        if (r_q[0]) r_acc <= r_acc + r_b;
        r_b <= r_b << 1;
        r_q <= r_q >> 1;
      end else if (w_fits) begin
        r_rem <= w_diff;
        r_q   <= {r_q[W-2:0], 1'b1};
      end else begin
        r_rem <= w_shifted[W-1:0];
        r_q   <= {r_q[W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    case (r_op)
      OP_MUL:  o_result = r_acc;
      OP_DIVU: o_result = r_q;
      OP_REMU: o_result = r_rem;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIV/REM, registered as the
// EX/MEM boundary. Stall holds the ID/EX latch while the iterative unit runs.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int W     = 16,
  parameter int ITERS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] readData0,
  input  logic [W-1:0] readData1,
  input  logic [3:0]   ALUOp,
  input  logic         ReadMem,
  input  logic         WriteMem,
  input  logic [W-1:0] DataIn,
  input  logic [1:0]   quarter,
  input  logic         write,
  input  logic [3:0]   writeReg,
  input  logic         flush,
  output logic         stall,
  output logic [W-1:0] o_aluResult,
  output logic         o_ReadMem,
  output logic         o_WriteMem,
  output logic [W-1:0] o_DataIn,
  output logic [1:0]   o_quarter,
  output logic         o_write,
  output logic [3:0]   o_writeReg
);

  localparam int CW = $clog2(ITERS);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_lReadMem;
  logic          r_lWriteMem;
  logic [W-1:0]  r_lDataIn;
  logic [1:0]    r_lQuarter;
  logic          r_lWrite;
  logic [3:0]    r_lWriteReg;

  logic          w_isMulti;
  logic          w_start;
  logic          w_step;
  logic          w_loadLive;
  logic          w_loadDone;
  logic [3:0]    w_shamt;
  logic [W-1:0]  w_aluResult;
  logic [W-1:0]  w_mduResult;

  assign w_isMulti  = is_multi(ALUOp);
  assign w_start    = !flush && (r_state == ST_IDLE) && w_isMulti;
  assign w_step     = !flush && (r_state == ST_BUSY);
  assign w_loadLive = !flush && (r_state == ST_IDLE) && !w_isMulti;
  assign w_loadDone = !flush && (r_state == ST_DONE);
  assign stall      = !rst && !flush &&
                      (((r_state == ST_IDLE) && w_isMulti) || (r_state == ST_BUSY));

  always_comb begin
    w_shamt     = readData1[3:0];
    w_aluResult = '0;
    case (ALUOp)
      OP_ADD:   w_aluResult = readData0 + readData1;
      OP_SUB:   w_aluResult = readData0 - readData1;
      OP_AND:   w_aluResult = readData0 & readData1;
      OP_OR:    w_aluResult = readData0 | readData1;
      OP_XOR:   w_aluResult = readData0 ^ readData1;
      OP_SLL:   w_aluResult = readData0 << w_shamt;
      OP_SRL:   w_aluResult = readData0 >> w_shamt;
      OP_SRA:   w_aluResult = W'($signed(readData0) >>> w_shamt);
      OP_SLT:   w_aluResult = {{(W-1){1'b0}}, ($signed(readData0) < $signed(readData1))};
      OP_SLTU:  w_aluResult = {{(W-1){1'b0}}, (readData0 < readData1)};
      OP_PASSB: w_aluResult = readData1;
      OP_PASSA: w_aluResult = readData0;
      default:  w_aluResult = '0;
    endcase
  end

  mdu_iter #(.W(W)) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_step   (w_step),
    .i_op     (ALUOp),
    .i_a      (readData0),
    .i_b      (readData1),
    .o_result (w_mduResult)
  );

  // Controls are captured at accept time because upstream is free to move on once stall drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_lReadMem  <= 1'b0;
      r_lWriteMem <= 1'b0;
      r_lDataIn   <= '0;
      r_lQuarter  <= '0;
      r_lWrite    <= 1'b0;
      r_lWriteReg <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_isMulti) begin
            r_state     <= ST_BUSY;
            r_cnt       <= CW'(ITERS - 1);
            r_lReadMem  <= ReadMem;
            r_lWriteMem <= WriteMem;
            r_lDataIn   <= DataIn;
            r_lQuarter  <= quarter;
            r_lWrite    <= write;
            r_lWriteReg <= writeReg;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) r_state <= ST_DONE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Anything other than a live single-cycle op or a finished multi op leaves a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_aluResult <= '0;
      o_ReadMem   <= 1'b0;
      o_WriteMem  <= 1'b0;
      o_DataIn    <= '0;
      o_quarter   <= '0;
      o_write     <= 1'b0;
      o_writeReg  <= '0;
    end else if (w_loadLive) begin
      o_aluResult <= w_aluResult;
      o_ReadMem   <= ReadMem;
      o_WriteMem  <= WriteMem;
      o_DataIn    <= DataIn;
      o_quarter   <= quarter;
      o_write     <= write;
      o_writeReg  <= writeReg;
    end else if (w_loadDone) begin
      o_aluResult <= w_mduResult;
      o_ReadMem   <= r_lReadMem;
      o_WriteMem  <= r_lWriteMem;
      o_DataIn    <= r_lDataIn;
      o_quarter   <= r_lQuarter;
      o_write     <= r_lWrite;
      o_writeReg  <= r_lWriteReg;
    end else begin
      o_aluResult <= '0;
      o_ReadMem   <= 1'b0;
      o_WriteMem  <= 1'b0;
      o_DataIn    <= '0;
      o_quarter   <= '0;
      o_write     <= 1'b0;
      o_writeReg  <= '0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and compared when the stage presents its result.
module tb_ex_stage;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] readData0, readData1, DataIn;
  logic [3:0]   ALUOp, writeReg;
  logic         ReadMem, WriteMem, write, flush;
  logic [1:0]   quarter;
  logic         stall;
  logic [W-1:0] o_aluResult, o_DataIn;
  logic         o_ReadMem, o_WriteMem, o_write;
  logic [1:0]   o_quarter;
  logic [3:0]   o_writeReg;

  typedef struct {
    logic [W-1:0] res;
    logic         rm;
    logic         wm;
    logic [W-1:0] din;
    logic [1:0]   q;
    logic         wr;
    logic [3:0]   wreg;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } vec_t;

  exp_t        sbq[$];
  int          nChecks = 0;
  int          nFails  = 0;
  logic [40:0] outVec;

  assign outVec = {o_aluResult, o_ReadMem, o_WriteMem, o_DataIn, o_quarter, o_write, o_writeReg};

  ex_stage #(.W(W), .ITERS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .readData0   (readData0),
    .readData1   (readData1),
    .ALUOp       (ALUOp),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .quarter     (quarter),
    .write       (write),
    .writeReg    (writeReg),
    .flush       (flush),
    .stall       (stall),
    .o_aluResult (o_aluResult),
    .o_ReadMem   (o_ReadMem),
    .o_WriteMem  (o_WriteMem),
    .o_DataIn    (o_DataIn),
    .o_quarter   (o_quarter),
    .o_write     (o_write),
    .o_writeReg  (o_writeReg)
  );

  always #5 clk = ~clk;

  function automatic logic [40:0] packExp(input exp_t e);
    return {e.res, e.rm, e.wm, e.din, e.q, e.wr, e.wreg};
  endfunction

  function automatic logic [W-1:0] refMulti(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] p;
    p = a * b;
    case (op)
      4'd10:   return p[15:0];
      4'd11:   return (b == 0) ? 16'hFFFF : a / b;
      4'd12:   return (b == 0) ? a : a % b;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rm, input logic wm, input logic [W-1:0] din,
                       input logic [1:0] q, input logic wr, input logic [3:0] wreg);
    ALUOp = op; readData0 = a; readData1 = b;
    ReadMem = rm; WriteMem = wm; DataIn = din; quarter = q; write = wr; writeReg = wreg;
  endtask

  task automatic driveRandCtl(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(op, a, b, 1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
  endtask

  task automatic pushCur(input logic [W-1:0] res);
    exp_t e;
    e = '{res, ReadMem, WriteMem, DataIn, quarter, write, writeReg};
    sbq.push_back(e);
  endtask

  task automatic pushBubble();
    exp_t e;
    e = '{16'h0, 1'b0, 1'b0, 16'h0, 2'b0, 1'b0, 4'h0};
    sbq.push_back(e);
  endtask

  task automatic waitStallDrop(output int nStall, output logic bubbleOk, output logic timedOut);
    nStall = 0; bubbleOk = 1'b1; timedOut = 1'b0;
    #1;
    while (stall === 1'b1 && nStall < 40) begin
      nStall++;
      @(posedge clk); #1;
      if (outVec !== 41'h0) bubbleOk = 1'b0;
    end
    if (stall !== 1'b0) timedOut = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; flush = 1'b0;
    drive(4'd0, 16'h0, 16'h0, 0, 0, 16'h0, 2'd0, 0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (outVec !== 41'h0 || stall !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_state: got out=%h stall=%b, want 0 / 0", outVec, stall);
    end
    rst = 1'b0;
    drive(4'd0, 16'h1111, 16'h2222, 1, 1, 16'hC0DE, 2'd3, 1, 4'd9);
    pushCur(16'h3333);
    @(posedge clk); #1;
    e = sbq.pop_front();
    nChecks++;
    if (outVec !== packExp(e)) begin
      nFails++; $display("[TB] FAIL reset_first_add: got %h, want %h", outVec, packExp(e));
    end
    rst = 1'b1;
    #1;
    nChecks++;
    if (outVec !== 41'h0 || stall !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_async: got out=%h stall=%b, want 0 / 0", outVec, stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_ops();
    vec_t t[15];
    exp_t e;
    t = '{'{4'd0,  16'h7FFF, 16'h0001, 16'h8000},
          '{4'd7,  16'h8000, 16'h0004, 16'hF800},
          '{4'd1,  16'h0000, 16'h0001, 16'hFFFF},
          '{4'd2,  16'hF0F0, 16'h3C3C, 16'h3030},
          '{4'd3,  16'hF0F0, 16'h0F00, 16'hFFF0},
          '{4'd4,  16'hAAAA, 16'hFFFF, 16'h5555},
          '{4'd5,  16'h0001, 16'h000F, 16'h8000},
          '{4'd5,  16'h0003, 16'h0011, 16'h0006},
          '{4'd6,  16'h8000, 16'h000F, 16'h0001},
          '{4'd8,  16'hFFFF, 16'h0001, 16'h0001},
          '{4'd9,  16'hFFFF, 16'h0001, 16'h0000},
          '{4'd8,  16'h0005, 16'hFFFB, 16'h0000},
          '{4'd13, 16'h1234, 16'h5678, 16'h5678},
          '{4'd14, 16'h1234, 16'h5678, 16'h1234},
          '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000}};
    for (int i = 0; i < 15; i++) begin
      if (i == 0) drive(t[i].op, t[i].a, t[i].b, 0, 0, 16'h0, 2'd0, 1, 4'd3);
      else if (i == 14) drive(t[i].op, t[i].a, t[i].b, 0, 0, 16'hBEEF, 2'd1, 0, 4'd2);
      else driveRandCtl(t[i].op, t[i].a, t[i].b);
      pushCur(t[i].res);
      #1;
      nChecks++;
      if (stall !== 1'b0) begin
        nFails++; $display("[TB] FAIL single_stall[%0d]: got %b, want 0", i, stall);
      end
      @(posedge clk); #1;
      e = sbq.pop_front();
      nChecks++;
      if (outVec !== packExp(e)) begin
        nFails++; $display("[TB] FAIL single_op[%0d] op=%0d: got %h, want %h", i, t[i].op, outVec, packExp(e));
      end
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int   n;
    logic bOk, to;
    drive(4'd10, 16'h0123, 16'h0010, 0, 1, 16'hABCD, 2'd2, 1, 4'd5);
    pushCur(16'h1230);
    waitStallDrop(n, bOk, to);
    nChecks++;
    if (n != 17 || to) begin
      nFails++; $display("[TB] FAIL mul_stall_cycles: got %0d (timeout=%b), want 17", n, to);
    end
    nChecks++;
    if (!bOk) begin
      nFails++; $display("[TB] FAIL mul_bubble: got non-bubble output while stalled, want all zero");
    end
    drive(4'd10, 16'h0123, 16'h0010, 1, 0, 16'h0000, 2'd0, 0, 4'd9);
    @(posedge clk); #1;
    e = sbq.pop_front();
    nChecks++;
    if (outVec !== packExp(e)) begin
      nFails++; $display("[TB] FAIL mul_result: got %h, want %h", outVec, packExp(e));
    end
    drive(4'd14, 16'h0, 16'h0, 0, 0, 16'h0, 2'd0, 0, 4'd0);
  endtask

  task automatic test_div();
    vec_t t[4];
    exp_t e;
    int   n;
    logic bOk, to;
    t = '{'{4'd11, 16'd100, 16'd7, 16'h000E},
          '{4'd12, 16'd100, 16'd7, 16'h0002},
          '{4'd11, 16'd5,   16'd0, 16'hFFFF},
          '{4'd12, 16'd5,   16'd0, 16'h0005}};
    for (int i = 0; i < 4; i++) begin
      driveRandCtl(t[i].op, t[i].a, t[i].b);
      pushCur(t[i].res);
      waitStallDrop(n, bOk, to);
      nChecks++;
      if (n != 17 || to || !bOk) begin
        nFails++; $display("[TB] FAIL div_stall[%0d]: got %0d cycles (timeout=%b bubble=%b), want 17", i, n, to, bOk);
      end
      @(posedge clk); #1;
      e = sbq.pop_front();
      nChecks++;
      if (outVec !== packExp(e)) begin
        nFails++; $display("[TB] FAIL div_result[%0d]: got %h, want %h", i, outVec, packExp(e));
      end
      drive(4'd14, 16'h0, 16'h0, 0, 0, 16'h0, 2'd0, 0, 4'd0);
    end
  endtask

  task automatic test_reset_mid_busy();
    exp_t e;
    int   n;
    logic bOk, to;
    drive(4'd10, 16'h00FF, 16'h0002, 1, 1, 16'h1234, 2'd1, 1, 4'd4);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    nChecks++;
    if (outVec !== 41'h0 || stall !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_mid_busy: got out=%h stall=%b, want 0 / 0", outVec, stall);
    end
    @(posedge clk); #1;
    drive(4'd10, 16'h0003, 16'h0005, 0, 0, 16'h0042, 2'd3, 1, 4'd6);
    pushCur(16'h000F);
    rst = 1'b0;
    waitStallDrop(n, bOk, to);
    nChecks++;
    if (n != 17 || to || !bOk) begin
      nFails++; $display("[TB] FAIL after_reset_stall: got %0d cycles (timeout=%b bubble=%b), want 17", n, to, bOk);
    end
    @(posedge clk); #1;
    e = sbq.pop_front();
    nChecks++;
    if (outVec !== packExp(e)) begin
      nFails++; $display("[TB] FAIL after_reset_result: got %h, want %h", outVec, packExp(e));
    end
    drive(4'd14, 16'h0, 16'h0, 0, 0, 16'h0, 2'd0, 0, 4'd0);
  endtask

  task automatic test_flush();
    exp_t e;
    drive(4'd10, 16'h0123, 16'h0010, 1, 0, 16'h5555, 2'd2, 1, 4'd8);
    repeat (3) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    pushBubble();
    #1;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_busy_stall: got %b, want 0", stall);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    e = sbq.pop_front();
    nChecks++;
    if (outVec !== packExp(e)) begin
      nFails++; $display("[TB] FAIL flush_busy_bubble: got %h, want %h", outVec, packExp(e));
    end
    drive(4'd0, 16'h0002, 16'h0003, 0, 0, 16'h0, 2'd0, 1, 4'd7);
    pushCur(16'h0005);
    #1;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_idle_state: got stall %b, want 0", stall);
    end
    @(posedge clk); #1;
    e = sbq.pop_front();
    nChecks++;
    if (outVec !== packExp(e)) begin
      nFails++; $display("[TB] FAIL flush_then_add: got %h, want %h", outVec, packExp(e));
    end
    drive(4'd10, 16'h0004, 16'h0004, 1, 1, 16'h7777, 2'd1, 1, 4'd1);
    flush = 1'b1;
    pushBubble();
    #1;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_beats_accept_stall: got %b, want 0", stall);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    e = sbq.pop_front();
    nChecks++;
    if (outVec !== packExp(e)) begin
      nFails++; $display("[TB] FAIL flush_beats_accept_bubble: got %h, want %h", outVec, packExp(e));
    end
    drive(4'd0, 16'h0002, 16'h0003, 0, 0, 16'h0, 2'd0, 1, 4'd7);
    pushCur(16'h0005);
    #1;
    nChecks++;
    if (stall !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_not_accepted: got stall %b, want 0", stall);
    end
    @(posedge clk); #1;
    e = sbq.pop_front();
    nChecks++;
    if (outVec !== packExp(e)) begin
      nFails++; $display("[TB] FAIL flush_second_add: got %h, want %h", outVec, packExp(e));
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[5];
    exp_t e;
    int   n;
    logic bOk, to;
    t[0] = '{4'd11, 16'hBEEF, 16'h0013, 16'h0A0C};
    t[1] = '{4'd10, 16'h1234, 16'h0100, 16'h3400};
    for (int i = 2; i < 5; i++) begin
      t[i].op  = 4'(10 + $urandom_range(0, 2));
      t[i].a   = 16'($urandom);
      t[i].b   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      t[i].res = refMulti(t[i].op, t[i].a, t[i].b);
    end
    for (int i = 0; i < 5; i++) begin
      driveRandCtl(t[i].op, t[i].a, t[i].b);
      pushCur(t[i].res);
      waitStallDrop(n, bOk, to);
      nChecks++;
      if (n != 17 || to || !bOk) begin
        nFails++; $display("[TB] FAIL b2b_stall[%0d]: got %0d cycles (timeout=%b bubble=%b), want 17", i, n, to, bOk);
      end
      @(posedge clk); #1;
      e = sbq.pop_front();
      nChecks++;
      if (outVec !== packExp(e)) begin
        nFails++; $display("[TB] FAIL b2b_result[%0d] op=%0d a=%h b=%h: got %h, want %h",
                           i, t[i].op, t[i].a, t[i].b, outVec, packExp(e));
      end
    end
    drive(4'd14, 16'h0, 16'h0, 0, 0, 16'h0, 2'd0, 0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_ops();
    test_mul();
    test_div();
    test_reset_mid_busy();
    test_flush();
    test_back_to_back();
    nChecks++;
    if (sbq.size() != 0) begin
      nFails++; $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
